// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
// Sequencing controller for the stopwatch counter datapath. It debounces the
// raw push-buttons into single-cycle press pulses and runs an IDLE/RUN/PAUSE
// FSM. The FSM drives the counter clear, a prescaled count strobe and the
// display freeze flag.
//
// Optional feature macro: STOPWATCH_LAP_EN
//   defined   : lap button is debounced; a lap press in RUN toggles lap_hold
//   undefined : no lap debouncer, btn_lap ignored, lap_hold is always 0
//
// Parameters
//   DEB_CYCLES : consecutive stable-high synced cycles needed to accept a press
//   PRESC      : clock cycles per cnt_en strobe (>= 2)
//
// Ports
//   clk      in   system clock, rising edge
//   clr      in   synchronous active-low reset
//   btn_ss   in   raw start/stop button, active-high, asynchronous
//   btn_rst  in   raw reset button, active-high, asynchronous
//   btn_lap  in   raw lap button, active-high, asynchronous
//   cnt_rst  out  counter clear (registered)
//   cnt_en   out  one-cycle counter increment strobe (registered)
//   lap_hold out  freeze display while counter keeps running (registered)
//   running  out  high while the FSM is in RUN (registered)
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int unsigned DEB_CYCLES = 5000,
    parameter int unsigned PRESC      = 250000
) (
    input  logic clk,
    input  logic clr,
    input  logic btn_ss,
    input  logic btn_rst,
    input  logic btn_lap,
    output logic cnt_rst,
    output logic cnt_en,
    output logic lap_hold,
    output logic running
);

    localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
    localparam int unsigned PW = $clog2(PRESC);

    localparam int unsigned B_SS  = 0;
    localparam int unsigned B_RST = 1;
`ifdef STOPWATCH_LAP_EN
    localparam int unsigned B_LAP = 2;
    localparam int unsigned NB    = 3;
`else
    localparam int unsigned NB    = 2;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // Button capture: 2-flop synchronizer + saturating stable-high counter
    // ---------------------------------------------------------------------
    logic [NB-1:0] raw;
    logic [NB-1:0] sync1;
    logic [NB-1:0] sync2;
    logic [NB-1:0] lvl_q;
    logic [NB-1:0] lvl_c;
    logic [NB-1:0] press_c;
    logic [DW-1:0] deb_cnt [NB];

`ifdef STOPWATCH_LAP_EN
    assign raw = {btn_lap, btn_rst, btn_ss};
`else
    assign raw = {btn_rst, btn_ss};

    // btn_lap has no function in this build
    logic unused_lap;
    assign unused_lap = btn_lap;
`endif

    // Synchronizers, debounce counters and previous debounced level
    always_ff @(posedge clk) begin
        if (!clr) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl_q <= '0;
            for (int i = 0; i < int'(NB); i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            lvl_q <= lvl_c;
            for (int i = 0; i < int'(NB); i++) begin
                if (!sync2[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] != DW'(DEB_CYCLES)) begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
        end
    end

    // Debounced level is combinational from the counter so the press pulse
    // appears in the same cycle the counter reaches DEB_CYCLES.
    always_comb begin
        lvl_c   = '0;
        press_c = '0;
        for (int i = 0; i < int'(NB); i++) begin
            lvl_c[i]   = (deb_cnt[i] == DW'(DEB_CYCLES));
            press_c[i] = lvl_c[i] & ~lvl_q[i];
        end
    end

    logic ss_c;
    logic rst_c;
    logic lap_c;

    assign ss_c  = press_c[B_SS];
    assign rst_c = press_c[B_RST];
`ifdef STOPWATCH_LAP_EN
    assign lap_c = press_c[B_LAP];
`else
    assign lap_c = 1'b0;
`endif

    // ---------------------------------------------------------------------
    // FSM and prescaler
    // ---------------------------------------------------------------------
    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;
    logic          cnt_rst_nxt;
    logic          cnt_en_nxt;
    logic          lap_hold_nxt;
    logic          presc_tc_c;

    assign presc_tc_c = (presc == PW'(PRESC - 1));

    // State, prescaler and registered outputs
    always_ff @(posedge clk) begin
        if (!clr) begin
            state    <= IDLE;
            presc    <= '0;
            cnt_rst  <= 1'b1;
            cnt_en   <= 1'b0;
            lap_hold <= 1'b0;
            running  <= 1'b0;
        end else begin
            state    <= state_nxt;
            presc    <= presc_nxt;
            cnt_rst  <= cnt_rst_nxt;
            cnt_en   <= cnt_en_nxt;
            lap_hold <= lap_hold_nxt;
            running  <= (state_nxt == RUN);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt    = state;
        presc_nxt    = presc;
        cnt_rst_nxt  = 1'b0;
        cnt_en_nxt   = 1'b0;
        lap_hold_nxt = lap_hold;

        case (state)
            IDLE: begin
                // rst and lap have no effect while idle
                if (ss_c) begin
                    state_nxt = RUN;
                    presc_nxt = '0;
                end
            end

            RUN: begin
                // Prescaler advances every RUN cycle, including the cycle a
                // pause is taken, so a terminal count is never lost.
                cnt_en_nxt = presc_tc_c;
                presc_nxt  = presc_tc_c ? '0 : presc + PW'(1);
                if (ss_c) begin
                    state_nxt = PAUSE;
                end else if (lap_c) begin
                    lap_hold_nxt = ~lap_hold;
                end
            end

            PAUSE: begin
                // Prescaler holds so the partial period survives a pause
                if (rst_c) begin
                    state_nxt    = IDLE;
                    cnt_rst_nxt  = 1'b1;
                    lap_hold_nxt = 1'b0;
                end else if (ss_c) begin
                    state_nxt = RUN;
                end
            end

            default: begin
                state_nxt    = IDLE;
                presc_nxt    = '0;
                cnt_rst_nxt  = 1'b1;
                lap_hold_nxt = 1'b0;
            end
        endcase
    end

endmodule
